// File: rtl/mcs4.sv
// Shared MCS-4 definitions: bank geometry defaults, bus-cycle encoding,
// RAM addressing and the I/O-group OPA codes.
package mcs4;

  localparam int Ram_chips_per_bank = 4;
  localparam int Ram_regs_per_chip  = 4;
  localparam int Ram_chars_per_reg  = 16;
  localparam int Ram_status_per_reg = 4;

  typedef enum logic [2:0] {
    CYC_A1, CYC_A2, CYC_A3, CYC_M1, CYC_M2, CYC_X1, CYC_X2, CYC_X3
  } instr_cyc_t;

  typedef struct packed {
    logic [1:0] chip;
    logic [1:0] rg;
    logic [3:0] chr;
  } ram_addr_t;

  localparam logic [3:0] WRM = 4'h0;
  localparam logic [3:0] WMP = 4'h1;
  localparam logic [3:0] WRR = 4'h2;
  localparam logic [3:0] WR0 = 4'h4;
  localparam logic [3:0] WR1 = 4'h5;
  localparam logic [3:0] WR2 = 4'h6;
  localparam logic [3:0] WR3 = 4'h7;
  localparam logic [3:0] SBM = 4'h8;
  localparam logic [3:0] RDM = 4'h9;
  localparam logic [3:0] RDR = 4'hA;
  localparam logic [3:0] ADM = 4'hB;
  localparam logic [3:0] RD0 = 4'hC;
  localparam logic [3:0] RD1 = 4'hD;
  localparam logic [3:0] RD2 = 4'hE;
  localparam logic [3:0] RD3 = 4'hF;

  function automatic instr_cyc_t next_cyc(input instr_cyc_t c);
    case (c)
      CYC_A1:  return CYC_A2;
      CYC_A2:  return CYC_A3;
      CYC_A3:  return CYC_M1;
      CYC_M1:  return CYC_M2;
      CYC_M2:  return CYC_X1;
      CYC_X1:  return CYC_X2;
      CYC_X2:  return CYC_X3;
      default: return CYC_A1;
    endcase
  endfunction

endpackage

// File: rtl/mcs4_cycle_tracker.sv
// Follows the eight-cycle instruction rhythm from sync; o_cyc names the
// bus cycle currently on the bus and is only meaningful while o_synced=1.
module mcs4_cycle_tracker
  import mcs4::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sync,
  output instr_cyc_t o_cyc,
  output logic       o_synced
);

  instr_cyc_t r_cyc;
  logic       r_synced;

  // sync names the current cycle A1 immediately, so the decode sees it in
  // the same clock rather than one bus cycle late.
  always_comb begin
    o_cyc    = i_sync ? CYC_A1 : next_cyc(r_cyc);
    o_synced = i_sync | r_synced;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc    <= CYC_A1;
      r_synced <= 1'b0;
    end else begin
      r_cyc    <= o_cyc;
      r_synced <= o_synced;
    end
  end

endmodule

// File: rtl/mcs4_ram_bank.sv
// 4002-style RAM bank on one CM-RAM line: SRC addressing, main/status
// character storage, per-chip output ports and registered X2 read-back.
module mcs4_ram_bank
  import mcs4::*;
#(
  parameter int NUM_CHIPS      = Ram_chips_per_bank,
  parameter int REGS_PER_CHIP  = Ram_regs_per_chip,
  parameter int CHARS_PER_REG  = Ram_chars_per_reg,
  parameter int STATUS_PER_REG = Ram_status_per_reg
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sync,
  input  logic                   cm_ram,
  input  logic [3:0]             data_in,
  output logic [3:0]             data_out,
  output logic                   data_oe,
  output logic [4*NUM_CHIPS-1:0] out_port
);

  localparam int CharBits  = (CHARS_PER_REG > 1) ? $clog2(CHARS_PER_REG) : 1;
  localparam int MainDepth = NUM_CHIPS * REGS_PER_CHIP * CHARS_PER_REG;
  localparam int StatDepth = NUM_CHIPS * REGS_PER_CHIP * STATUS_PER_REG;
  localparam int MainAw    = (MainDepth > 1) ? $clog2(MainDepth) : 1;
  localparam int StatAw    = (StatDepth > 1) ? $clog2(StatDepth) : 1;

  instr_cyc_t w_cyc;
  logic       w_synced;

  ram_addr_t               r_sel;
  logic                    r_src_pend;
  logic [3:0]              r_opa;
  logic                    r_opa_vld;
  logic [3:0]              r_main [MainDepth];
  logic [3:0]              r_stat [StatDepth];
  logic [4*NUM_CHIPS-1:0]  r_out_port;
  logic [3:0]              r_data_out;
  logic                    r_data_oe;

  logic              w_selected;
  logic              w_main_ok;
  logic              w_stat_ok;
  int                w_reg_base;
  int                w_char;
  int                w_stat_num;
  logic [MainAw-1:0] w_main_idx;
  logic [StatAw-1:0] w_stat_idx;
  logic              w_rd_oe;
  logic [3:0]        w_rd_data;

  mcs4_cycle_tracker u_tracker (
    .clk      (clk),
    .rst      (rst),
    .i_sync   (sync),
    .o_cyc    (w_cyc),
    .o_synced (w_synced)
  );

  // Character index wraps on its own bit width; a non-power-of-two register
  // length additionally rejects the unused tail.
  always_comb begin
    w_selected = (int'(r_sel.chip) < NUM_CHIPS) && (int'(r_sel.rg) < REGS_PER_CHIP);
    w_char     = int'(r_sel.chr) & ((1 << CharBits) - 1);
    w_stat_num = int'(r_opa[1:0]);
    w_main_ok  = w_selected && (w_char < CHARS_PER_REG);
    w_stat_ok  = w_selected && (w_stat_num < STATUS_PER_REG);
    w_reg_base = int'(r_sel.chip) * REGS_PER_CHIP + int'(r_sel.rg);
    w_main_idx = MainAw'(w_reg_base * CHARS_PER_REG + w_char);
    w_stat_idx = StatAw'(w_reg_base * STATUS_PER_REG + w_stat_num);
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_rd_oe   = 1'b0;
    w_rd_data = 4'h0;
    if (w_selected) begin
      case (r_opa)
        SBM, RDM, ADM: begin
          w_rd_oe = w_main_ok;
          if (w_main_ok) w_rd_data = r_main[w_main_idx];
        end
        RD0, RD1, RD2, RD3: begin
          w_rd_oe = 1'b1;
          if (w_stat_ok) w_rd_data = r_stat[w_stat_idx];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel      <= '0;
      r_src_pend <= 1'b0;
      r_opa      <= 4'h0;
      r_opa_vld  <= 1'b0;
      r_out_port <= '0;
      r_data_out <= 4'h0;
      r_data_oe  <= 1'b0;
      // NOTE: storage is reset because software expects cleared RAM after
      // reset; most RAM macros cannot do this, so these stay flop arrays.
      r_main     <= '{default: 4'h0};
      r_stat     <= '{default: 4'h0};
    end else begin
      r_src_pend <= 1'b0;
      r_data_oe  <= 1'b0;
      r_data_out <= 4'h0;
      if (w_synced) begin
        case (w_cyc)
          CYC_A1: r_opa_vld <= 1'b0;
          CYC_M2: begin
            if (cm_ram) begin
              r_opa     <= data_in;
              r_opa_vld <= 1'b1;
            end
          end
          // Read data is registered here so it is on the bus for all of X2.
          CYC_X1: begin
            if (r_opa_vld) begin
              r_data_oe  <= w_rd_oe;
              r_data_out <= w_rd_data;
            end
          end
          CYC_X2: begin
            if (r_opa_vld) begin
              r_opa_vld <= 1'b0;
              case (r_opa)
                WRM: if (w_main_ok) r_main[w_main_idx] <= data_in;
                WR0, WR1, WR2, WR3: if (w_stat_ok) r_stat[w_stat_idx] <= data_in;
                WMP: begin
                  for (int c = 0; c < NUM_CHIPS; c++) begin
                    if (int'(r_sel.chip) == c) r_out_port[4*c +: 4] <= data_in;
                  end
                end
                default: ;
              endcase
            end else if (cm_ram) begin
              r_sel.chip <= data_in[3:2];
              r_sel.rg   <= data_in[1:0];
              r_src_pend <= 1'b1;
            end
          end
          CYC_X3: if (r_src_pend) r_sel.chr <= data_in;
          default: ;
        endcase
      end
    end
  end

  assign data_out = r_data_out;
  assign data_oe  = r_data_oe;
  assign out_port = r_out_port;

endmodule

// File: tb/tb_mcs4_ram_bank.sv
// Scoreboard bench for mcs4_ram_bank (3 chips): reads push expected nibbles,
// a negedge monitor pops and compares whenever data_oe is high.
module tb_mcs4_ram_bank;

  localparam int NCH = 3;

  localparam int PH_IDLE = -1;
  localparam int PH_A1 = 0, PH_A2 = 1, PH_A3 = 2, PH_M1 = 3;
  localparam int PH_M2 = 4, PH_X1 = 5, PH_X2 = 6, PH_X3 = 7;

  localparam logic [3:0] OP_WRM = 4'h0, OP_WMP = 4'h1, OP_WRR = 4'h2, OP_WPM = 4'h3;
  localparam logic [3:0] OP_WR0 = 4'h4, OP_WR2 = 4'h6;
  localparam logic [3:0] OP_SBM = 4'h8, OP_RDM = 4'h9, OP_RDR = 4'hA, OP_ADM = 4'hB;
  localparam logic [3:0] OP_RD0 = 4'hC, OP_RD1 = 4'hD, OP_RD2 = 4'hE;

  logic             clk = 1'b0;
  logic             rst;
  logic             sync;
  logic             cm_ram;
  logic [3:0]       data_in;
  logic [3:0]       data_out;
  logic             data_oe;
  logic [4*NCH-1:0] out_port;

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         phase  = PH_IDLE;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  mcs4_ram_bank #(
    .NUM_CHIPS      (NCH),
    .REGS_PER_CHIP  (4),
    .CHARS_PER_REG  (16),
    .STATUS_PER_REG (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sync     (sync),
    .cm_ram   (cm_ram),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .out_port (out_port)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic s, input logic cm, input logic [3:0] d, input int p);
    @(posedge clk);
    #1;
    sync    = s;
    cm_ram  = cm;
    data_in = d;
    phase   = p;
  endtask

  task automatic instr(input logic cm_m2, input logic [3:0] opa, input logic cm_x2,
                       input logic [3:0] x2d, input logic [3:0] x3d);
    cyc(1'b1, 1'b0, 4'h0, PH_A1);
    cyc(1'b0, 1'b0, 4'h0, PH_A2);
    cyc(1'b0, 1'b0, 4'h0, PH_A3);
    cyc(1'b0, 1'b0, 4'h0, PH_M1);
    cyc(1'b0, cm_m2, opa, PH_M2);
    cyc(1'b0, 1'b0, 4'h0, PH_X1);
    cyc(1'b0, cm_x2, x2d, PH_X2);
    cyc(1'b0, 1'b0, x3d, PH_X3);
  endtask

  task automatic src(input logic [3:0] chip_reg, input logic [3:0] chr);
    instr(1'b0, 4'h0, 1'b1, chip_reg, chr);
  endtask

  task automatic io(input logic [3:0] opa, input logic [3:0] d);
    instr(1'b1, opa, 1'b0, d, 4'h0);
  endtask

  task automatic rd(input logic [3:0] opa, input logic [3:0] exp);
    exp_q.push_back(exp);
    io(opa, 4'h0);
  endtask

  // Monitor: any data_oe must fall in X2 and match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (data_oe === 1'b1) begin
        check("oe_phase", phase, PH_X2);
        if (exp_q.size() == 0) check("unexpected_oe", 1, 0);
        else check("rd_data", data_out, exp_q.pop_front());
      end else begin
        check("oe_low", data_oe, 1'b0);
        check("idle_data_out", data_out, 4'h0);
      end
    end
  end

  initial begin
    rst = 1'b1; sync = 1'b0; cm_ram = 1'b0; data_in = 4'h0;
    repeat (3) cyc(1'b0, 1'b0, 4'h0, PH_IDLE);
    @(negedge clk);
    check("rst_oe", data_oe, 1'b0);
    check("rst_data_out", data_out, 4'h0);
    check("rst_out_port", out_port, 12'h000);
    rst = 1'b0;

    // Chip 1, reg 2, char 5: write main then read back
    src(4'b0110, 4'h5);
    io(OP_WRM, 4'hA);
    rd(OP_RDM, 4'hA);

    // Status characters
    io(OP_WR2, 4'h7);
    rd(OP_RD2, 4'h7);
    rd(OP_RD1, 4'h0);
    rd(OP_RDM, 4'hA);

    // Output port of chip 1
    @(negedge clk);
    check("port_before_wmp", out_port, 12'h000);
    io(OP_WMP, 4'h9);
    @(negedge clk);
    check("port_wmp_x3", out_port, 12'h090);
    rd(OP_ADM, 4'hA);
    rd(OP_SBM, 4'hA);

    // Ignored opcodes
    io(OP_WRR, 4'hF);
    io(OP_WPM, 4'hF);
    io(OP_RDR, 4'h0);
    @(negedge clk);
    check("port_after_ignored", out_port, 12'h090);
    rd(OP_RDM, 4'hA);

    // Chip 3 is out of range for a 3-chip bank
    src(4'b1100, 4'h5);
    io(OP_WRM, 4'hF);
    io(OP_RDM, 4'h0);
    io(OP_RD0, 4'h0);
    io(OP_WMP, 4'hF);
    @(negedge clk);
    check("port_deselected", out_port, 12'h090);
    src(4'b0000, 4'h5);
    rd(OP_RDM, 4'h0);
    src(4'b0110, 4'h5);
    rd(OP_RDM, 4'hA);

    // cm_ram in both M2 and X2: I/O only, selection unchanged
    instr(1'b1, OP_WRM, 1'b1, 4'h3, 4'h0);
    rd(OP_RDM, 4'h3);

    // sync in M1 before the opcode is seen: no write
    cyc(1'b1, 1'b0, 4'h0, PH_A1);
    cyc(1'b0, 1'b0, 4'h0, PH_A2);
    cyc(1'b0, 1'b0, 4'h0, PH_A3);
    cyc(1'b1, 1'b0, 4'h0, PH_A1);
    cyc(1'b0, 1'b1, OP_WRM, PH_A2);
    cyc(1'b0, 1'b0, 4'h0, PH_A3);
    cyc(1'b0, 1'b0, 4'hF, PH_M1);
    cyc(1'b0, 1'b0, 4'h0, PH_M2);
    rd(OP_RDM, 4'h3);

    // sync in X1 after WR0 was latched: pending opcode discarded
    cyc(1'b1, 1'b0, 4'h0, PH_A1);
    cyc(1'b0, 1'b0, 4'h0, PH_A2);
    cyc(1'b0, 1'b0, 4'h0, PH_A3);
    cyc(1'b0, 1'b0, 4'h0, PH_M1);
    cyc(1'b0, 1'b1, OP_WR0, PH_M2);
    cyc(1'b1, 1'b0, 4'h0, PH_A1);
    cyc(1'b0, 1'b0, 4'h0, PH_A2);
    cyc(1'b0, 1'b0, 4'h0, PH_A3);
    cyc(1'b0, 1'b0, 4'h0, PH_M1);
    cyc(1'b0, 1'b0, 4'h0, PH_M2);
    cyc(1'b0, 1'b0, 4'h0, PH_X1);
    cyc(1'b0, 1'b0, 4'hE, PH_X2);
    cyc(1'b0, 1'b0, 4'h0, PH_X3);
    rd(OP_RD0, 4'h0);

    // Reset during X1 of RDM: no output, state cleared, unsynced after
    cyc(1'b1, 1'b0, 4'h0, PH_A1);
    cyc(1'b0, 1'b0, 4'h0, PH_A2);
    cyc(1'b0, 1'b0, 4'h0, PH_A3);
    cyc(1'b0, 1'b0, 4'h0, PH_M1);
    cyc(1'b0, 1'b1, OP_RDM, PH_M2);
    cyc(1'b0, 1'b0, 4'h0, PH_X1);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 4'h0, PH_X2);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 4'h0, PH_X3);
    @(negedge clk);
    check("port_after_rst", out_port, 12'h000);
    cyc(1'b0, 1'b0, 4'h0, PH_IDLE);
    cyc(1'b0, 1'b1, OP_WMP, PH_IDLE);
    cyc(1'b0, 1'b0, 4'h0, PH_IDLE);
    cyc(1'b0, 1'b0, 4'h5, PH_IDLE);
    cyc(1'b0, 1'b0, 4'h0, PH_IDLE);
    cyc(1'b0, 1'b0, 4'h0, PH_IDLE);
    @(negedge clk);
    check("port_unsynced", out_port, 12'h000);

    // Reset selection is chip 0 reg 0 char 0; memory cleared
    io(OP_WRM, 4'h6);
    src(4'b0110, 4'h5);
    rd(OP_RDM, 4'h0);
    rd(OP_RD2, 4'h0);
    src(4'b0000, 4'h0);
    rd(OP_RDM, 4'h6);

    repeat (4) cyc(1'b0, 1'b0, 4'h0, PH_IDLE);
    check("pending_reads", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mcs4_ram_bank.md
Name: mcs4_ram_bank

Overview:
- Parametrised 4002-style RAM bank model for one CM-RAM line: main characters, status characters and a 4-bit output port per chip.
- Generalises fixed chip/register/character counts to parameters and adds out-of-range chip deselection.
- Sits on the CPU's abstracted 4-bit data bus (separate in/out plus output enable) beside the CPU and ROM.
- Decodes SRC addressing and I/O-group instructions from bus cycles A1..X3.

Parameters:
- NUM_CHIPS, 4, chips in this bank (1..4); chip select field stays 2 bits.
- REGS_PER_CHIP, 4, registers per chip (power of 2, ≤4).
- CHARS_PER_REG, 16, main characters per register.
- STATUS_PER_REG, 4, status characters per register.

Ports:
- clk  in  1  system clock; one clock = one bus cycle.
- rst  in  1  synchronous, active-high reset.
- sync  in  1  high during the A1 cycle of each instruction.
- cm_ram  in  1  CPU command line for this bank.
- data_in  in  4  CPU-driven bus character.
- data_out  out  4  RAM-driven bus character.
- data_oe  out  1  data_out valid; CPU samples it in X2.
- out_port  out  4*NUM_CHIPS  per-chip output port; chip c occupies [4c+3:4c].

Behaviour:
- Cycle tracker (instr_cyc_t):
  - After rst the tracker is UNSYNCED and performs no action.
  - sync=1 forces A1 in that cycle. Otherwise it advances A1→A2→A3→M1→M2→X1→X2→X3→A1.
  - sync during any non-A1 cycle resynchronises to A1 and discards any pending I/O opcode.
- SRC capture:
  - cm_ram=1 in X2 latches data_in[3:2] as chip and data_in[1:0] as reg.
  - In X3 of the same instruction, data_in is latched as char.
  - The selection persists until the next SRC.
- Deselection:
  - The bank is deselected if chip ≥ NUM_CHIPS or reg ≥ REGS_PER_CHIP.
  - While deselected, writes are ignored and data_oe stays 0.
- I/O decode:
  - cm_ram=1 in M2 latches data_in as a pending OPA, flagged valid.
  - The opcode executes in X2 of the same instruction; valid clears at X3.
- Write ops (sample data_in at the X2 clock edge; storage updated from X3):
  - WRM: main[chip][reg][char].
  - WR0..WR3: status[chip][reg][OPA[1:0]].
  - WMP: out_port of the selected chip.
  - For STATUS_PER_REG<4, an index ≥ STATUS_PER_REG is ignored.
- Read ops (data_out/data_oe registered, asserted exactly during X2 and 0 in every other cycle):
  - RDM, SBM, ADM: main character.
  - RD0..RD3: status character. A status index ≥ STATUS_PER_REG returns 0 with data_oe=1.
- Ignored OPAs: WRR, RDR and 4'b0011 have no effect.
- Both lines active in one instruction: cm_ram=1 in both M2 and X2 is treated as I/O only; X2 capture is suppressed.
- Character index truncation: char uses $clog2(CHARS_PER_REG) bits, so when CHARS_PER_REG<16 the upper bits are ignored (wrap).
- Reset state:
  - All main/status storage = 0; out_port = 0; data_out = 0; data_oe = 0.
  - Selection = chip 0, reg 0, char 0; tracker UNSYNCED; pending op cleared.
  - rst mid-instruction aborts the instruction; the next action needs a fresh sync.

Decomposition:
- Add to package mcs4:
  - Parameters Ram_chips_per_bank, Ram_regs_per_chip, Ram_chars_per_reg, Ram_status_per_reg.
  - Typedefs instr_cyc_t and ram_addr_t.
  - I/O OPA constants WRM..RD3.
- Sub-module mcs4_cycle_tracker: sync → instr_cyc_t plus a synced flag. It is reused by the ROM model.
- The storage arrays stay inline.

Test Plan:
- Reset; sync; SRC with X2=4'b0110, X3=4'h5; WRM with X2 data 4'hA; RDM → data_oe=1 only in X2, data_out=4'hA. Chip 1 reg 2 char 5 holds A.
- WR2 with data 4'h7, then RD2 → 4'h7; RD1 → 4'h0. Main char unchanged.
- NUM_CHIPS=2: SRC chip 3; WRM 4'hF → no write. RDM → data_oe stays 0. Re-SRC chip 0 → reads 0.
- WMP 4'h9 with chip 1 selected → out_port=16'h0090 from X3 onward; chip 0 port stays 0.
- sync asserted in M1 of an I/O instruction (cm_ram=1 at M2 not yet seen) → no write occurs; the tracker restarts at A1.
- rst asserted during X1 of RDM → data_oe never rises; out_port=0, memory cleared, UNSYNCED until the next sync.
